// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
// Owns the single write port of the integer register file. Two result
// streams are merged here:
//   - ALU results: single cycle, never stalled, always win the port;
//   - long-latency (load, mul/div) results: buffered in a DEPTH-entry FIFO
//     behind a valid/ready handshake and drained when the ALU leaves the
//     port idle.
// Also keeps a per-register pending scoreboard so that decode can stall on
// registers that are still waiting for a long-latency result.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   alu_v/alu_rd/alu_wd       ALU result stream
//   lsu_v/lsu_rdy/lsu_rd/lsu_wd  long-latency result stream (valid/ready)
//   iss_v/iss_rd              long-latency op issued (sets pending bit)
//   q_ra1/q_ra2, busy1/busy2  scoreboard queries (combinational)
//   we/wa/wd                  register file write port (registered)
module regfile_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_v,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_wd,
    input  logic        lsu_v,
    output logic        lsu_rdy,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_wd,
    input  logic        iss_v,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  q_ra1,
    input  logic [4:0]  q_ra2,
    output logic        busy1,
    output logic        busy2,
    output logic        we,
    output logic [4:0]  wa,
    output logic [31:0] wd
);

    localparam logic [PTRW:0] FULL = DEPTH[PTRW:0];

    logic [4:0]      fifo_rd [DEPTH];
    logic [31:0]     fifo_wd [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [PTRW:0]   count;
    logic [31:0]     pend;

    logic        alu_sel;
    logic        push;
    logic        pop;
    logic [4:0]  head_rd;
    logic [31:0] head_wd;
    logic [31:0] pend_nxt;

    // Ready depends only on registered occupancy, never on lsu_v.
    assign lsu_rdy = !rst && (count != FULL);

    assign head_rd = fifo_rd[rd_ptr];
    assign head_wd = fifo_wd[rd_ptr];

    always_comb begin
        alu_sel = alu_v && (alu_rd != 5'd0);
        // Results for x0 are accepted (handshake completes) but dropped.
        push    = lsu_v && lsu_rdy && (lsu_rd != 5'd0);
        // An ALU write to x0 leaves the port free for the FIFO head.
        pop     = !alu_sel && (count != '0);
    end

    // Clear from the popped head first, then set from issue, so a new issue
    // to the same register on the same edge keeps the bit set.
    always_comb begin
        pend_nxt = pend;
        if (pop)
            pend_nxt[head_rd] = 1'b0;
        if (iss_v && (iss_rd != 5'd0))
            pend_nxt[iss_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    assign busy1 = pend[q_ra1];
    assign busy2 = pend[q_ra2];

    always_ff @(posedge clk) begin
        if (rst) begin
            we     <= 1'b0;
            wa     <= '0;
            wd     <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            pend   <= '0;
        end else begin
            if (alu_sel) begin
                we <= 1'b1;
                wa <= alu_rd;
                wd <= alu_wd;
            end else if (pop) begin
                we <= 1'b1;
                wa <= head_rd;
                wd <= head_wd;
            end else begin
                we <= 1'b0;
            end

            if (push) begin
                fifo_rd[wr_ptr] <= lsu_rd;
                fifo_wd[wr_ptr] <= lsu_wd;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            pend <= pend_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wd;
    logic        lsu_v;
    logic        lsu_rdy;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_wd;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic [4:0]  q_ra1;
    logic [4:0]  q_ra2;
    logic        busy1;
    logic        busy2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;

    int compared = 0;
    int mismatched = 0;

    regfile_wb_ctrl #(.DEPTH(4), .PTRW(2)) dut (
        .clk(clk), .rst(rst),
        .alu_v(alu_v), .alu_rd(alu_rd), .alu_wd(alu_wd),
        .lsu_v(lsu_v), .lsu_rdy(lsu_rdy), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
        .iss_v(iss_v), .iss_rd(iss_rd),
        .q_ra1(q_ra1), .q_ra2(q_ra2), .busy1(busy1), .busy2(busy2),
        .we(we), .wa(wa), .wd(wd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset with busy inputs
        rst = 1'b1;
        alu_v = 1'b1; alu_rd = 5'd5; alu_wd = 32'h1;
        lsu_v = 1'b1; lsu_rd = 5'd3; lsu_wd = 32'h4;
        iss_v = 1'b0; iss_rd = 5'd0;
        q_ra1 = 5'd3; q_ra2 = 5'd5;
        tick();
        tick();
        chk("rst_we", we, 0);
        chk("rst_wa", wa, 0);
        chk("rst_wd", wd, 0);
        chk("rst_rdy", lsu_rdy, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_busy2", busy2, 0);
        rst = 1'b0; alu_v = 1'b0; lsu_v = 1'b0;
        #1;
        chk("rdy_after_rst", lsu_rdy, 1);
        tick();
        chk("idle_we", we, 0);

        // ALU path
        alu_v = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
        tick();
        alu_v = 1'b0;
        chk("alu_we", we, 1);
        chk("alu_wa", wa, 5);
        chk("alu_wd", wd, 32'hDEADBEEF);
        tick();
        chk("alu_we_off", we, 0);
        chk("alu_wa_hold", wa, 5);

        // priority: ALU holds port for 3 cycles while one long result waits
        alu_v = 1'b1; alu_rd = 5'd3; alu_wd = 32'h22;
        lsu_v = 1'b1; lsu_rd = 5'd7; lsu_wd = 32'h11;
        tick();
        lsu_v = 1'b0;
        chk("prio_wa1", wa, 3);
        chk("prio_wd1", wd, 32'h22);
        tick();
        chk("prio_wa2", wa, 3);
        tick();
        chk("prio_wa3", wa, 3);
        alu_v = 1'b0;
        tick();
        chk("fifo_we", we, 1);
        chk("fifo_wa", wa, 7);
        chk("fifo_wd", wd, 32'h11);
        tick();
        chk("fifo_empty_we", we, 0);
        chk("fifo_empty_rdy", lsu_rdy, 1);

        // fill, backpressure, drain in order
        alu_v = 1'b1; alu_rd = 5'd9; alu_wd = 32'h99;
        for (int i = 1; i <= 4; i++) begin
            lsu_v = 1'b1; lsu_rd = 5'(i); lsu_wd = 32'h100 + 32'(i);
            chk("fill_rdy", lsu_rdy, 1);
            tick();
            chk("fill_alu_wa", wa, 9);
        end
        chk("full_rdy", lsu_rdy, 0);
        lsu_rd = 5'd5; lsu_wd = 32'h105;
        tick();
        chk("bp_rdy", lsu_rdy, 0);
        chk("bp_wa", wa, 9);
        alu_v = 1'b0;
        tick();
        chk("drain_wa1", wa, 1);
        chk("drain_wd1", wd, 32'h101);
        chk("rdy_after_pop", lsu_rdy, 1);
        tick();
        lsu_v = 1'b0;
        chk("drain_wa2", wa, 2);
        for (int i = 3; i <= 5; i++) begin
            tick();
            chk("drain_we", we, 1);
            chk("drain_wa", wa, 32'(i));
            chk("drain_wd", wd, 32'h100 + 32'(i));
        end
        tick();
        chk("drain_done_we", we, 0);

        // second pass of 4 across the pointer wrap
        alu_v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lsu_v = 1'b1; lsu_rd = 5'(20 + i); lsu_wd = 32'h200 + 32'(i);
            tick();
        end
        lsu_v = 1'b0;
        chk("wrap_full_rdy", lsu_rdy, 0);
        alu_v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wrap_wa", wa, 32'(20 + i));
            chk("wrap_wd", wd, 32'h200 + 32'(i));
        end
        tick();
        chk("wrap_done_we", we, 0);

        // scoreboard set and clear by pop
        iss_v = 1'b1; iss_rd = 5'd12; q_ra1 = 5'd12; q_ra2 = 5'd13;
        tick();
        iss_v = 1'b0;
        chk("sb_set_busy1", busy1, 1);
        chk("sb_other_busy2", busy2, 0);
        alu_v = 1'b1; alu_rd = 5'd9;
        lsu_v = 1'b1; lsu_rd = 5'd12; lsu_wd = 32'hC;
        tick();
        lsu_v = 1'b0;
        chk("sb_hold1", busy1, 1);
        tick();
        chk("sb_hold2", busy1, 1);
        alu_v = 1'b0;
        tick();
        chk("sb_pop_wa", wa, 12);
        chk("sb_clear_busy1", busy1, 0);

        // set wins over clear on the same edge
        iss_v = 1'b1; iss_rd = 5'd12; q_ra2 = 5'd12;
        tick();
        iss_v = 1'b0;
        chk("sb_reset_busy1", busy1, 1);
        alu_v = 1'b1;
        lsu_v = 1'b1; lsu_rd = 5'd12; lsu_wd = 32'hCC;
        tick();
        lsu_v = 1'b0; alu_v = 1'b0;
        iss_v = 1'b1; iss_rd = 5'd12;
        tick();
        iss_v = 1'b0;
        chk("sb_setwin_wa", wa, 12);
        chk("sb_setwin_wd", wd, 32'hCC);
        chk("sb_setwin_busy1", busy1, 1);
        chk("sb_setwin_busy2", busy2, 1);

        // rd=0 filtering on the long-latency stream
        lsu_v = 1'b1; lsu_rd = 5'd0; lsu_wd = 32'hBAD;
        tick();
        lsu_v = 1'b0;
        chk("rd0_lsu_we", we, 0);
        tick();
        chk("rd0_lsu_we2", we, 0);
        alu_v = 1'b1; alu_rd = 5'd9;
        lsu_v = 1'b1; lsu_rd = 5'd0; lsu_wd = 32'hBAD;
        tick();
        for (int i = 0; i < 3; i++) begin
            lsu_rd = 5'(14 + i); lsu_wd = 32'h300 + 32'(i);
            tick();
        end
        lsu_v = 1'b0;
        chk("rd0_count_rdy", lsu_rdy, 1);
        // ALU write to x0 lets the FIFO head through
        alu_rd = 5'd0; alu_wd = 32'h77;
        tick();
        alu_v = 1'b0;
        chk("rd0_alu_we", we, 1);
        chk("rd0_alu_wa", wa, 14);
        chk("rd0_alu_wd", wd, 32'h300);
        tick();
        chk("rd0_wa15", wa, 15);
        tick();
        chk("rd0_wa16", wa, 16);
        tick();
        chk("rd0_empty_we", we, 0);

        // issue to x0 never marks pending
        iss_v = 1'b1; iss_rd = 5'd0; q_ra1 = 5'd0;
        tick();
        iss_v = 1'b0;
        chk("iss0_busy1", busy1, 0);

        // reset mid-operation drops buffered results and pending bits
        alu_v = 1'b1; alu_rd = 5'd9;
        lsu_v = 1'b1; lsu_rd = 5'd17; lsu_wd = 32'h17;
        q_ra1 = 5'd12;
        tick();
        lsu_v = 1'b0; alu_v = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy1", busy1, 0);
        chk("midrst_we", we, 0);
        tick();
        chk("midrst_no_write", we, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
Writeback controller that owns the integer register file's single write port (write-enable, write-address, write-data). It merges two result streams:
- single-cycle ALU results, which are never stalled and have priority;
- long-latency results from load and mul/div, buffered in a small FIFO behind a valid/ready handshake.

It also keeps a per-register pending scoreboard. Decode uses it to stall on registers still awaiting a long-latency result.

Parameters:
DEPTH, 4, FIFO entries for long-latency results; power of two, at least 2.
PTRW, 2, pointer width, equal to log2(DEPTH).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
alu_v  in  1  ALU result valid this cycle
alu_rd  in  5  ALU destination register
alu_wd  in  32  ALU result data
lsu_v  in  1  long-latency result valid
lsu_rdy  out  1  FIFO can accept a result
lsu_rd  in  5  long-latency destination register
lsu_wd  in  32  long-latency result data
iss_v  in  1  a long-latency op is issued this cycle
iss_rd  in  5  destination of the issued op
q_ra1  in  5  scoreboard query address 1
q_ra2  in  5  scoreboard query address 2
busy1  out  1  pend[q_ra1], combinational
busy2  out  1  pend[q_ra2], combinational
we  out  1  register file write-enable, registered
wa  out  5  register file write-address, registered
wd  out  32  register file write-data, registered

Behaviour:
Interface rules
- One clock: clk. Reset rst is synchronous and active-high.
- While rst is high, at each clk edge: we=0, wa=0, wd=0, FIFO emptied (pointers=0, count=0), pend=0.
- lsu_rdy=0 while rst is high. Otherwise lsu_rdy = (count != DEPTH), derived from registered count only, never from lsu_v.
- A long-latency result is accepted on an edge where lsu_v & lsu_rdy.
  - Accepted entries with lsu_rd=0 are discarded; they are not pushed.
  - The upstream producer holds lsu_rd/lsu_wd stable until accepted.

Per-edge write-port selection, using pre-edge state
- alu_v=1 and alu_rd!=0: we<=1, wa<=alu_rd, wd<=alu_wd. FIFO head is not popped.
- Else if FIFO is non-empty: pop the head; we<=1, wa<=head.rd, wd<=head.wd. This includes alu_v=1 with alu_rd=0, so rd=0 ALU results free the slot.
- Else: we<=0. wa/wd hold their previous values.

Timing
- Latency: ALU result at edge t gives we=1 in the cycle after edge t.
- Long-latency result accepted at edge t can be written no earlier than edge t+1, so we=1 in the cycle after t+1. There is no FIFO bypass.
- Push and pop on the same edge are both honoured; count is unchanged. This is legal when full: the pop frees a slot, but lsu_rdy already showed 0, so no push occurs.
- FIFO pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Write order between the two streams is not preserved. Correctness relies on the scoreboard.

Scoreboard pend[31:0]
- iss_v with iss_rd!=0 sets pend[iss_rd].
- A FIFO pop with head.rd = r clears pend[r] on the same edge that loads we/wa/wd.
- If set and clear target the same register on the same edge, set wins; this is a newly issued op.
- pend[0] is always 0. ALU writes never touch pend.
- busy1/busy2 read the post-edge pend state combinationally.

Reset mid-operation
- Buffered results are lost and pend is cleared. Upstream flushes in-flight ops on the same rst.

Test Plan:
- Reset: hold rst 2 cycles with alu_v=1, lsu_v=1 -> we=0, wa=0, wd=0, lsu_rdy=0, busy1=busy2=0. lsu_rdy=1 in the first cycle after rst falls.
- ALU path: alu_v=1, alu_rd=5, alu_wd=0xDEADBEEF for one cycle -> next cycle we=1, wa=5, wd=0xDEADBEEF; the following cycle we=0.
- Priority and FIFO:
  - Push lsu_rd=7, wd=0x11 while alu_v=1, rd=3, wd=0x22 for 3 cycles.
  - Expected: wa=3 for 3 cycles, then wa=7, wd=0x11. FIFO count returns to 0.
- Full, wrap and backpressure:
  - Stream 5 results (rd 1..5) with alu_v held at 1 and rd=9.
  - Expected: lsu_rdy=0 after 4 accepts.
  - Then release alu_v: writes appear in order 1,2,3,4, and lsu_rdy=1 after the first pop. Result 5 is accepted and written last. Verify pointer wrap on a second pass of 4.
- Scoreboard:
  - iss_v with iss_rd=12, then q_ra1=12 -> busy1=1 until the pop writing wa=12. busy1=0 the cycle after that edge.
  - iss_rd=12 issued on the same edge as that pop -> busy1 stays 1.
- rd=0 filtering:
  - lsu_rd=0 accepted -> never written, count unchanged.
  - alu_rd=0 with FIFO non-empty -> head written that cycle.
  - iss_rd=0 -> busy stays 0 for q_ra1=0.
